matmul_operand_loader: RTL
==========================

Name: matmul_operand_loader

Overview:
Upstream stage of the matmul calculation unit. On a start pulse it fetches the full A and B operand matrices, one bus word per row, from the scratchpad over a single read port. When mode_i is set it also fetches the C bias matrix, one bus word per element. It assembles the words into long vectors and presents them to the matmul unit with a valid/ack handshake.

Parameters:
DATA_WIDTH, 8, operand element width
BUS_WIDTH, 16, scratchpad word width and C element width
ADDR_WIDTH, 32, scratchpad address width
(localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH; IDXW = $clog2(MAX_DIM))

Ports:
clk_i  in  1  clock
rst  in  1  reset, synchronous, active-low
start_i  in  1  begin fetch; sampled only in IDLE
mode_i  in  1  1 = also fetch C bias; latched with start_i
ack_i  in  1  downstream consumed operands; honoured only in DONE
rd_en_o  out  1  read strobe to scratchpad
rd_addr_o  out  ADDR_WIDTH  read address
rd_data_i  in  BUS_WIDTH  read data, valid exactly 1 cycle after the rd_en_o cycle
a_matrix_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  A; row r at [r*BUS_WIDTH +: BUS_WIDTH]
b_matrix_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  B; row r at [r*BUS_WIDTH +: BUS_WIDTH]
c_bias_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  C bias; element e at [e*BUS_WIDTH +: BUS_WIDTH]
valid_o  out  1  operands complete and stable
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (rst==0 at a clk_i edge): state IDLE. All outputs 0. Any in-flight read is discarded. Applies mid-fetch as well.
- Address map:
  - A row r: addr[4:0]=5'b00100, addr[5 +: IDXW]=r.
  - B row r: addr[4:0]=5'b01000, addr[5 +: IDXW]=r.
  - C element e: addr[4:0]=5'b10000, addr[5 +: 2*IDXW]=e.
  - All other address bits are 0. rd_addr_o is 0 whenever rd_en_o is 0.
- FSM states and transitions:
  - IDLE: on start_i, latch mode_i, clear a/b/c outputs to 0, go to FETCH_A.
  - FETCH_A: issue rows 0..MAX_DIM-1, one per cycle, then go to FETCH_B.
  - FETCH_B: same for B. Then go to FETCH_C if the latched mode is 1, else DRAIN.
  - FETCH_C: issue elements 0..MAX_DIM*MAX_DIM-1, one per cycle, then go to DRAIN.
  - DRAIN: rd_en_o=0; capture the last returned word, then go to DONE.
  - DONE: valid_o=1. On ack_i go to IDLE; valid_o falls on that edge.
- rd_en_o is 1 in every FETCH_* cycle, with no gaps.
- Capture: a registered (target, index) tag follows each issue by one cycle. rd_data_i is written into the tagged slice on the edge ending the cycle after issue.
- Total issues N = 2*MAX_DIM + mode*MAX_DIM*MAX_DIM.
  - rd_en_o first high in the cycle after the start-sampling edge.
  - valid_o rises on edge N+1 after the start-sampling edge.
  - MAX_DIM=2: 5 edges for mode 0, 9 edges for mode 1.
- With mode=0, c_bias_o stays all zero.
- Output vectors hold their values from DONE through IDLE until the next accepted start.
- Ignored inputs:
  - start_i outside IDLE, including start_i and ack_i together in DONE: ack wins and start is dropped.
  - ack_i outside DONE.
  - mode_i changes after start.
- busy_o is 1 from the edge after start until the ack edge.
- No arithmetic. Data is stored bit-exact; sign is not interpreted.

Test Plan:
- Memory, MAX_DIM=2:
  - A0=16'h0201, A1=16'h0403, B0=16'h0605, B1=16'h0807.
  - C0..C3=16'h0010, 16'h0020, 16'h0030, 16'h0040.
- Mode 0 fetch: start=1, mode=0.
  - rd_addr sequence 0x04, 0x24, 0x08, 0x28 on consecutive cycles.
  - valid_o high on edge 5: a=32'h04030201, b=32'h08070605, c=0.
- Mode 1 fetch: after the A/B addresses, rd_addr sequence 0x10, 0x30, 0x50, 0x70.
  - valid_o on edge 9.
  - c_bias_o=64'h0040_0030_0020_0010.
- Handshake hold: withhold ack_i for 10 cycles.
  - valid_o and vectors stay stable, rd_en_o stays 0.
  - ack -> valid_o=0 and busy_o=0 the next cycle.
- Ignored inputs:
  - start_i pulsed during FETCH_B: no restart, addresses unchanged.
  - ack_i in IDLE: no effect.
  - start_i and ack_i together in DONE: returns to IDLE with no new fetch.
- Reset mid-fetch: rst=0 during FETCH_C.
  - Next cycle: state IDLE, all outputs 0, rd_en_o=0.
  - The late rd_data_i return is not captured.
  - A subsequent mode 0 start completes normally with the expected vectors.

Source files
------------

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader: fetches A/B rows (and optionally C bias elements)
// over one scratchpad read port and presents them with a valid/ack handshake.
// Ports: clk_i/rst (sync, active-low); start_i/mode_i/ack_i control;
//   rd_en_o/rd_addr_o/rd_data_i scratchpad port (1-cycle read latency);
//   a_matrix_o/b_matrix_o/c_bias_o operand vectors; valid_o/busy_o status.
module matmul_operand_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  ack_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [BUS_WIDTH-1:0]  rd_data_i,
  output logic [BUS_WIDTH*BUS_WIDTH/DATA_WIDTH-1:0] a_matrix_o,
  output logic [BUS_WIDTH*BUS_WIDTH/DATA_WIDTH-1:0] b_matrix_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)**2*BUS_WIDTH-1:0] c_bias_o,
  output logic                  valid_o,
  output logic                  busy_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int IDXW    = $clog2(MAX_DIM);
  localparam int CW      = 2 * IDXW;
  localparam int ABW     = MAX_DIM * MAX_DIM * DATA_WIDTH;
  localparam int CVW     = MAX_DIM * MAX_DIM * BUS_WIDTH;

  localparam logic [CW-1:0] LAST_R = CW'(MAX_DIM - 1);
  localparam logic [CW-1:0] LAST_E = CW'(MAX_DIM * MAX_DIM - 1);

  localparam logic [4:0] CODE_A = 5'b00100;
  localparam logic [4:0] CODE_B = 5'b01000;
  localparam logic [4:0] CODE_C = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    TGT_A,
    TGT_B,
    TGT_C
  } tgt_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  tag_vld_q, tag_vld_d;
  tgt_e                  tag_tgt_q, tag_tgt_d;
  logic [CW-1:0]         tag_idx_q, tag_idx_d;
  logic [ABW-1:0]        a_q, a_d;
  logic [ABW-1:0]        b_q, b_d;
  logic [CVW-1:0]        c_q, c_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [4:0]    code,
    input logic [CW-1:0] idx
  );
    logic [ADDR_WIDTH-1:0] a;
    a        = '0;
    a[4:0]   = code;
    a[5 +: CW] = idx;
    return a;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    rd_en_d = 1'b0;
    addr_d  = '0;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;

    // The tag marks which slice the word returning next cycle belongs to.
    tag_vld_d = rd_en_q;
    tag_idx_d = cnt_q;
    unique case (state_q)
      S_FETCH_B: tag_tgt_d = TGT_B;
      S_FETCH_C: tag_tgt_d = TGT_C;
      default:   tag_tgt_d = TGT_A;
    endcase

    if (tag_vld_q) begin
      unique case (tag_tgt_q)
        TGT_B:
          b_d[tag_idx_q[IDXW-1:0]*BUS_WIDTH +: BUS_WIDTH] = rd_data_i;
        TGT_C:
          c_d[tag_idx_q*BUS_WIDTH +: BUS_WIDTH] = rd_data_i;
        default:
          a_d[tag_idx_q[IDXW-1:0]*BUS_WIDTH +: BUS_WIDTH] = rd_data_i;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          a_d     = '0;
          b_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = S_FETCH_A;
          rd_en_d = 1'b1;
          addr_d  = addr_of(CODE_A, '0);
        end
      end
      S_FETCH_A: begin
        rd_en_d = 1'b1;
        if (cnt_q == LAST_R) begin
          cnt_d   = '0;
          state_d = S_FETCH_B;
          addr_d  = addr_of(CODE_B, '0);
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_of(CODE_A, cnt_q + CW'(1));
        end
      end
      S_FETCH_B: begin
        rd_en_d = 1'b1;
        if (cnt_q == LAST_R) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d = S_FETCH_C;
            addr_d  = addr_of(CODE_C, '0);
          end else begin
            state_d = S_DRAIN;
            rd_en_d = 1'b0;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_of(CODE_B, cnt_q + CW'(1));
        end
      end
      S_FETCH_C: begin
        rd_en_d = 1'b1;
        if (cnt_q == LAST_E) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_of(CODE_C, cnt_q + CW'(1));
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      tag_vld_q <= 1'b0;
      tag_tgt_q <= TGT_A;
      tag_idx_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      tag_vld_q <= tag_vld_d;
      tag_tgt_q <= tag_tgt_d;
      tag_idx_q <= tag_idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = addr_q;
  assign a_matrix_o = a_q;
  assign b_matrix_o = b_q;
  assign c_bias_o   = c_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;

endmodule
